// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing (default 640x480@60 from 100 MHz): coordinates, syncs, strobes.
// Optional macro VGA_RGB_BLANK_EN adds registered, blanked RGB with syncs delayed one pixel to match.
module vga_sync_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
`ifdef VGA_RGB_BLANK_EN
  input  logic       red_in,
  input  logic       green_in,
  input  logic       blue_in,
  output logic       red_out,
  output logic       green_out,
  output logic       blue_out,
`endif
  output logic [9:0] x_crd,
  output logic [9:0] y_crd,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_tick,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] r_d;
  logic [9:0]    r_h, r_v;
  logic          r_tick, r_hs, r_vs, r_vid, r_ls, r_fs;

  logic       w_upd, w_hwrap;
  logic [9:0] w_h_nxt, w_v_nxt;

  assign w_upd   = (r_d == D_LAST);
  assign w_hwrap = (r_h == H_LAST);
  assign w_h_nxt = w_hwrap ? 10'd0 : r_h + 10'd1;
  assign w_v_nxt = !w_hwrap ? r_v : ((r_v == V_LAST) ? 10'd0 : r_v + 10'd1);

  // Every decoded output is taken from the advanced counters so all stay coherent per pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d    <= '0;
      r_tick <= 1'b0;
      r_h    <= H_LAST;
      r_v    <= V_LAST;
      r_hs   <= ~SYNC_POL;
      r_vs   <= ~SYNC_POL;
      r_vid  <= 1'b0;
      r_ls   <= 1'b0;
      r_fs   <= 1'b0;
    end else if (w_upd) begin
      r_d    <= '0;
      r_tick <= 1'b1;
      r_h    <= w_h_nxt;
      r_v    <= w_v_nxt;
      r_hs   <= (w_h_nxt >= HS_BEG && w_h_nxt <= HS_END) ? SYNC_POL : ~SYNC_POL;
      r_vs   <= (w_v_nxt >= VS_BEG && w_v_nxt <= VS_END) ? SYNC_POL : ~SYNC_POL;
      r_vid  <= (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
      r_ls   <= (w_h_nxt == 10'd0);
      r_fs   <= (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
    end else begin
      r_d    <= r_d + 1'b1;
      r_tick <= 1'b0;
      r_ls   <= 1'b0;
      r_fs   <= 1'b0;
    end
  end

  assign x_crd       = r_h;
  assign y_crd       = r_v;
  assign video_on    = r_vid;
  assign pix_tick    = r_tick;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

`ifdef VGA_RGB_BLANK_EN
  logic r_hs_d, r_vs_d, r_red, r_grn, r_blu;

  // Colour arrives combinationally for the current pixel; blank with the pre-update video_on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs_d <= ~SYNC_POL;
      r_vs_d <= ~SYNC_POL;
      r_red  <= 1'b0;
      r_grn  <= 1'b0;
      r_blu  <= 1'b0;
    end else if (w_upd) begin
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
      r_red  <= red_in   & r_vid;
      r_grn  <= green_in & r_vid;
      r_blu  <= blue_in  & r_vid;
    end
  end

  assign hsync     = r_hs_d;
  assign vsync     = r_vs_d;
  assign red_out   = r_red;
  assign green_out = r_grn;
  assign blue_out  = r_blu;
`else
  assign hsync = r_hs;
  assign vsync = r_vs;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken raster (15x8), CLK_DIV=4 and CLK_DIV=1 instances.
// Expected values come from an edge-count model: pixel index = edges/CLK_DIV - 1.
module tb_vga_sync_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct { int x, y, hs, vs, vid, tick, ls, fs; } obs_t;
  typedef struct { int k; obs_t e; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic a_hs, a_vs, a_vid, a_tick, a_ls, a_fs;
  logic b_hs, b_vs, b_vid, b_tick, b_ls, b_fs;
  logic r_in = 1'b1, g_in = 1'b0, bl_in = 1'b0;
`ifdef VGA_RGB_BLANK_EN
  logic a_r, a_g, a_b, b_r, b_g, b_b;
  logic [2:0] rgb_a = 3'b0, rgb_b = 3'b0;
`endif

  vga_sync_gen #(.CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)) u_a (
    .clk(clk), .rst(rst),
`ifdef VGA_RGB_BLANK_EN
    .red_in(r_in), .green_in(g_in), .blue_in(bl_in),
    .red_out(a_r), .green_out(a_g), .blue_out(a_b),
`endif
    .x_crd(a_x), .y_crd(a_y), .hsync(a_hs), .vsync(a_vs), .video_on(a_vid),
    .pix_tick(a_tick), .line_start(a_ls), .frame_start(a_fs));

  vga_sync_gen #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                 .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)) u_b (
    .clk(clk), .rst(rst),
`ifdef VGA_RGB_BLANK_EN
    .red_in(r_in), .green_in(g_in), .blue_in(bl_in),
    .red_out(b_r), .green_out(b_g), .blue_out(b_b),
`endif
    .x_crd(b_x), .y_crd(b_y), .hsync(b_hs), .vsync(b_vs), .video_on(b_vid),
    .pix_tick(b_tick), .line_start(b_ls), .frame_start(b_fs));

  int checks = 0, failures = 0;
  int k = 0;  // edges since the last reset edge

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (k=%0d)", nm, act, exp, k);
    end
  endtask

  function automatic void pos(input int q, output int x, output int y);
    if (q < 0) begin x = HT - 1; y = VT - 1; end
    else begin x = q % HT; y = (q / HT) % VT; end
  endfunction

  function automatic obs_t model(input int kk, input int div);
    obs_t o;
    int u, q, x, y, px, py;
    u = kk / div;
    q = u - 1;
    pos(q, x, y);
`ifdef VGA_RGB_BLANK_EN
    pos(q - 1, px, py);
`else
    px = x; py = y;
`endif
    o.x    = x;
    o.y    = y;
    o.tick = (kk > 0 && kk % div == 0) ? 1 : 0;
    o.vid  = (u > 0 && x < HA && y < VA) ? 1 : 0;
    o.ls   = (o.tick == 1 && x == 0) ? 1 : 0;
    o.fs   = (o.ls == 1 && y == 0) ? 1 : 0;
    o.hs   = (px >= HA + HF && px < HA + HF + HS) ? 0 : 1;
    o.vs   = (py >= VA + VF && py < VA + VF + VS) ? 0 : 1;
    return o;
  endfunction

  function automatic obs_t obs_a();
    obs_t o;
    o.x = int'(a_x); o.y = int'(a_y); o.hs = int'(a_hs); o.vs = int'(a_vs);
    o.vid = int'(a_vid); o.tick = int'(a_tick); o.ls = int'(a_ls); o.fs = int'(a_fs);
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o.x = int'(b_x); o.y = int'(b_y); o.hs = int'(b_hs); o.vs = int'(b_vs);
    o.vid = int'(b_vid); o.tick = int'(b_tick); o.ls = int'(b_ls); o.fs = int'(b_fs);
    return o;
  endfunction

  task automatic chk_obs(input string t, input obs_t a, input obs_t e);
    cmp({t, ".x"}, a.x, e.x);
    cmp({t, ".y"}, a.y, e.y);
    cmp({t, ".hsync"}, a.hs, e.hs);
    cmp({t, ".vsync"}, a.vs, e.vs);
    cmp({t, ".video_on"}, a.vid, e.vid);
    cmp({t, ".pix_tick"}, a.tick, e.tick);
    cmp({t, ".line_start"}, a.ls, e.ls);
    cmp({t, ".frame_start"}, a.fs, e.fs);
  endtask

  // One clock: advance the model on the posedge, optionally check on the negedge.
  task automatic step(input bit chk);
`ifdef VGA_RGB_BLANK_EN
    logic [2:0] cin;
    cin = {r_in, g_in, bl_in};
`endif
    @(posedge clk);
    if (rst) begin
      k = 0;
`ifdef VGA_RGB_BLANK_EN
      rgb_a = 3'b0; rgb_b = 3'b0;
`endif
    end else begin
      k++;
`ifdef VGA_RGB_BLANK_EN
      if (k % 4 == 0) rgb_a = cin & {3{model(k - 1, 4).vid == 1}};
      rgb_b = cin & {3{model(k - 1, 1).vid == 1}};
`endif
    end
    @(negedge clk);
    if (chk) begin
      chk_obs("div4", obs_a(), model(k, 4));
      chk_obs("div1", obs_b(), model(k, 1));
`ifdef VGA_RGB_BLANK_EN
      cmp("div4.rgb", int'({a_r, a_g, a_b}), int'(rgb_a));
      cmp("div1.rgb", int'({b_r, b_g, b_b}), int'(rgb_b));
`endif
    end
    g_in  = 1'($urandom);
    bl_in = 1'($urandom);
  endtask

  vec_t tbl[12];

  initial begin
    int hs_x10, vs_y5;
    int n, last_a, last_b, per_a, per_b;
    bit seen;
`ifdef VGA_RGB_BLANK_EN
    hs_x10 = 1; vs_y5 = 1;   // syncs lag one pixel
`else
    hs_x10 = 0; vs_y5 = 0;
`endif
    tbl[0]  = '{0,   '{14, 7, 1, 1, 0, 0, 0, 0}};
    tbl[1]  = '{3,   '{14, 7, 1, 1, 0, 0, 0, 0}};
    tbl[2]  = '{4,   '{0,  0, 1, 1, 1, 1, 1, 1}};
    tbl[3]  = '{5,   '{0,  0, 1, 1, 1, 0, 0, 0}};
    tbl[4]  = '{8,   '{1,  0, 1, 1, 1, 1, 0, 0}};
    tbl[5]  = '{36,  '{8,  0, 1, 1, 0, 1, 0, 0}};
    tbl[6]  = '{44,  '{10, 0, hs_x10, 1, 0, 1, 0, 0}};
    tbl[7]  = '{48,  '{11, 0, 0, 1, 0, 1, 0, 0}};
    tbl[8]  = '{64,  '{0,  1, 1, 1, 1, 1, 1, 0}};
    tbl[9]  = '{244, '{0,  4, 1, 1, 0, 1, 1, 0}};
    tbl[10] = '{304, '{0,  5, 1, vs_y5, 0, 1, 1, 0}};
    tbl[11] = '{484, '{0,  0, 1, 1, 1, 1, 1, 1}};

    // Reset held 3 clks, then table vectors at fixed edge counts after release.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n = 0;
      while (k < tbl[i].k && n < 1000) begin step(1'b0); n++; end
      chk_obs($sformatf("tbl%0d", i), obs_a(), tbl[i].e);
    end

    // Frame period for both instances: 480 and 120 clks on this raster.
    last_a = -1; last_b = -1; per_a = 0; per_b = 0;
    for (int i = 0; i < 1200; i++) begin
      step(1'b1);
      if (a_fs) begin if (last_a >= 0) per_a = i - last_a; last_a = i; end
      if (b_fs) begin if (last_b >= 0) per_b = i - last_b; last_b = i; end
    end
    cmp("period.div4", per_a, 4 * HT * VT);
    cmp("period.div1", per_b, HT * VT);

    // Mid-frame reset for one clk at (5,2): reset values next, frame_start 4 clks after release.
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      step(1'b1);
      seen = (a_x == 10'd5 && a_y == 10'd2 && a_tick);
    end
    cmp("midrst.reached", int'(seen), 1);
    rst = 1'b1;
    step(1'b1);
    cmp("midrst.x", int'(a_x), HT - 1);
    cmp("midrst.y", int'(a_y), VT - 1);
    rst = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 50) begin step(1'b1); n++; seen = a_fs; end
    cmp("midrst.fs_delay", n, 4);

    // Randomized run with sporadic resets of random length.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) rst = 1'b1;
      else if (rst && $urandom_range(2) == 0) rst = 1'b0;
      step(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
